x_ramb_dp_asym_clr: RTL
=======================

Name: x_ramb_dp_asym_clr

Overview:
- Parametrised single-clock true-dual-port block RAM with independently configurable port widths over one flat bit array.
- Per-port write mode, optional output pipeline register, synchronous output reset and cross-port collision detection.
- Built-in clear engine zeroes the array after reset or on request.
- Successor to the fixed-geometry dual-clock RAMB4 primitives; used for width-converting buffers in the datapath.

Parameters:
- MEM_BITS, 4096: total array bits; power of two.
- WIDTH_A, 2: port A data width; power of two, divides MEM_BITS.
- WIDTH_B, 4: port B data width; power of two, divides MEM_BITS.
- WMODE_A, 0: port A write mode; 0=WRITE_FIRST, 1=READ_FIRST, 2=NO_CHANGE.
- WMODE_B, 0: port B write mode; same encoding as WMODE_A.
- OREG_A, 0: 1 adds an output pipeline register on port A.
- OREG_B, 0: 1 adds an output pipeline register on port B.
- CLEAR_ON_RESET, 1: 1 starts the clear engine on reset release.
- Derived: AW_A=log2(MEM_BITS/WIDTH_A), AW_B=log2(MEM_BITS/WIDTH_B), WMAX=max(WIDTH_A,WIDTH_B), CLR_WORDS=MEM_BITS/WMAX.

Ports:
- CLK  in  1  single clock, all logic on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- ADDRA  in  AW_A  port A word address.
- DIA  in  WIDTH_A  port A write data.
- ENA  in  1  port A enable.
- WEA  in  1  port A write enable.
- SRA  in  1  port A synchronous output reset.
- DOA  out  WIDTH_A  port A read data.
- ADDRB  in  AW_B  port B word address.
- DIB  in  WIDTH_B  port B write data.
- ENB  in  1  port B enable.
- WEB  in  1  port B write enable.
- SRB  in  1  port B synchronous output reset.
- DOB  out  WIDTH_B  port B read data.
- CLR  in  1  single-cycle request to zero the whole array.
- BUSY  out  1  clear engine active; port accesses ignored.
- COLL  out  1  registered pulse, same-cycle overlapping writes.

Behaviour:
- Mapping: port A word n = mem bits [n*WIDTH_A +: WIDTH_A]; port B word m = mem bits [m*WIDTH_B +: WIDTH_B]. Little-endian.
- Reset (RST=1, async): DOA=0, DOB=0, all pipeline regs=0, COLL=0, clear counter=0. FSM forced to CLEAR if CLEAR_ON_RESET=1 (BUSY=1), else IDLE (BUSY=0). Array contents are not touched asynchronously.
- FSM state IDLE:
  - CLR=1 -> CLEAR next cycle, counter=0.
  - Port accesses processed normally.
- FSM state CLEAR:
  - Each cycle writes zero to WMAX bits at counter*WMAX, then counter+1.
  - At counter=CLR_WORDS-1 the final word is written and the FSM returns to IDLE; BUSY drops in the following cycle.
  - Duration is exactly CLR_WORDS cycles.
  - ENA/ENB treated as 0; DOA/DOB hold their value; CLR ignored.
  - RST asserted mid-clear: state restarts per reset rules and the counter restarts from 0.
- Port access (per port, EN=1, not BUSY):
  - SR=1: output stage reg <= 0. A write still occurs if WE=1.
  - WE=0: read; data available at DO 1 cycle after the edge (OREG=0) or 2 cycles (OREG=1).
  - WE=1: write DI at the edge. Output stage by mode: WRITE_FIRST <= DI; READ_FIRST <= old content; NO_CHANGE holds.
  - EN=0: no write, output stage holds.
- OREG pipeline stage:
  - Loads every cycle from stage 1 regardless of EN.
  - SR also clears the OREG stage in the same cycle.
- Cross-port read during write, overlapping bits: the reading port returns the old content (read-before-write).
- Collision (both ports write, overlapping bit ranges, same cycle):
  - Overlapping bits take port B data.
  - Non-overlapping bits of each write land normally.
  - COLL=1 for exactly the following cycle.
- Address out of range cannot occur (widths derived); no wrap logic required.

Decomposition:
- Package x_ramb_pkg:
  - WMODE_WRITE_FIRST/READ_FIRST/NO_CHANGE constants.
  - clog2 function.
  - FSM state typedef (ST_IDLE, ST_CLEAR).
- Sub-module x_ramb_port_out: per-port output stage (mode mux, SR, optional OREG), instantiated twice.
- Array, write arbitration and clear FSM stay in the top module.

Test Plan:
- Reset release with defaults -> BUSY=1 for 1024 cycles, then 0; all reads return 0 (A addr 0-2047, B addr 0-1023).
- Width mapping: A writes addr6=2'b01, addr7=2'b10 -> B read addr3 gives DOB=4'b1001 one cycle later (OREG_B=0), two cycles later with OREG_B=1.
- Write modes: preload B addr5=4'hA, then write 4'h3 -> DOB=4'h3 (WRITE_FIRST) / 4'hA (READ_FIRST) / previous DOB (NO_CHANGE).
- Collision: A writes addr10=2'b11 and B writes addr5=4'b0000 in the same cycle -> B addr5 reads 4'b0000 and COLL pulses 1 cycle.
- Clear: CLR mid-operation after writing 4'hF everywhere -> BUSY for 1024 cycles, ENA pulses ignored, all data reads 0 afterwards.
- Reset mid-clear: RST at clear cycle 500 -> DOA=DOB=0 immediately; clear restarts at 0 and runs a full 1024 cycles.

Source files
------------

// File: rtl/x_ramb_pkg.sv
// Shared constants, state encoding and helpers for the asymmetric dual-port RAM.
package x_ramb_pkg;

  localparam int WMODE_WRITE_FIRST = 0;
  localparam int WMODE_READ_FIRST  = 1;
  localparam int WMODE_NO_CHANGE   = 2;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_CLEAR = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/x_ramb_port_out.sv
// Per-port output stage: write-mode mux, synchronous output reset, optional pipeline register.
module x_ramb_port_out
  import x_ramb_pkg::*;
#(
  parameter int W     = 2,
  parameter int WMODE = 0,
  parameter int OREG  = 0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         we_i,
  input  logic         sr_i,
  input  logic [W-1:0] di_i,
  input  logic [W-1:0] rd_i,
  output logic [W-1:0] do_o
);

  logic [W-1:0] s1_q, s1_d;

  // en_i already has the clear-engine gating applied by the top.
  always_comb begin
    s1_d = s1_q;
    if (en_i) begin
      if (sr_i) begin
        s1_d = '0;
      end else if (!we_i) begin
        s1_d = rd_i;
      end else if (WMODE == WMODE_WRITE_FIRST) begin
        s1_d = di_i;
      end else if (WMODE == WMODE_READ_FIRST) begin
        s1_d = rd_i;
      end else if (WMODE == WMODE_NO_CHANGE) begin
        s1_d = s1_q;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) s1_q <= '0;
    else       s1_q <= s1_d;
  end

  generate
    if (OREG != 0) begin : g_oreg
      logic [W-1:0] s2_q, s2_d;
      assign s2_d = (en_i && sr_i) ? '0 : s1_q;
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) s2_q <= '0;
        else       s2_q <= s2_d;
      end
      assign do_o = s2_q;
    end else begin : g_direct
      assign do_o = s1_q;
    end
  endgenerate

endmodule

// File: rtl/x_ramb_dp_asym_clr.sv
// Single-clock true-dual-port RAM with independent port widths over one flat bit array,
// collision flagging and a built-in array clear engine.
module x_ramb_dp_asym_clr
  import x_ramb_pkg::*;
#(
  parameter int MEM_BITS       = 4096,
  parameter int WIDTH_A        = 2,
  parameter int WIDTH_B        = 4,
  parameter int WMODE_A        = 0,
  parameter int WMODE_B        = 0,
  parameter int OREG_A         = 0,
  parameter int OREG_B         = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int AW_A      = clog2(MEM_BITS / WIDTH_A),
  localparam int AW_B      = clog2(MEM_BITS / WIDTH_B),
  localparam int WMAX      = (WIDTH_A > WIDTH_B) ? WIDTH_A : WIDTH_B,
  localparam int CLR_WORDS = MEM_BITS / WMAX
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [AW_A-1:0]    ADDRA,
  input  logic [WIDTH_A-1:0] DIA,
  input  logic               ENA,
  input  logic               WEA,
  input  logic               SRA,
  output logic [WIDTH_A-1:0] DOA,
  input  logic [AW_B-1:0]    ADDRB,
  input  logic [WIDTH_B-1:0] DIB,
  input  logic               ENB,
  input  logic               WEB,
  input  logic               SRB,
  output logic [WIDTH_B-1:0] DOB,
  input  logic               CLR,
  output logic               BUSY,
  output logic               COLL
);

  localparam int BW   = clog2(MEM_BITS);
  localparam int LW_A = clog2(WIDTH_A);
  localparam int LW_B = clog2(WIDTH_B);
  localparam int LW_M = clog2(WMAX);
  localparam int CW   = (CLR_WORDS > 1) ? clog2(CLR_WORDS) : 1;
  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  logic [MEM_BITS-1:0] mem_q;
  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                coll_q, coll_d;

  logic                busy;
  logic                en_a, wr_a, en_b, wr_b;
  logic [BW-1:0]       base_a, base_b, base_c;
  logic [BW:0]         lo_a, lo_b;
  logic                overlap;
  logic [WIDTH_A-1:0]  rd_a;
  logic [WIDTH_B-1:0]  rd_b;

  assign busy = (state_q == ST_CLEAR);
  assign BUSY = busy;
  assign COLL = coll_q;

  assign en_a = ENA & ~busy;
  assign en_b = ENB & ~busy;
  assign wr_a = en_a & WEA;
  assign wr_b = en_b & WEB;

  assign base_a = BW'(ADDRA) << LW_A;
  assign base_b = BW'(ADDRB) << LW_B;
  assign base_c = BW'(cnt_q) << LW_M;

  // Combinational reads of the pre-edge array give read-before-write across ports.
  assign rd_a = mem_q[base_a +: WIDTH_A];
  assign rd_b = mem_q[base_b +: WIDTH_B];

  assign lo_a    = {1'b0, base_a};
  assign lo_b    = {1'b0, base_b};
  assign overlap = (lo_a < lo_b + (BW+1)'(WIDTH_B)) && (lo_b < lo_a + (BW+1)'(WIDTH_A));
  assign coll_d  = wr_a & wr_b & overlap;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (CLR) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        if (cnt_q == CW'(CLR_WORDS - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      coll_q  <= coll_d;
    end
  end

  // Port B is written after port A so it owns any overlapping bits.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (busy) begin
        mem_q[base_c +: WMAX] <= '0;
      end else begin
        if (wr_a) mem_q[base_a +: WIDTH_A] <= DIA;
        if (wr_b) mem_q[base_b +: WIDTH_B] <= DIB;
      end
    end
  end

  x_ramb_port_out #(
    .W     (WIDTH_A),
    .WMODE (WMODE_A),
    .OREG  (OREG_A)
  ) u_out_a (
    .clk_i (CLK),
    .rst_i (RST),
    .en_i  (en_a),
    .we_i  (WEA),
    .sr_i  (SRA),
    .di_i  (DIA),
    .rd_i  (rd_a),
    .do_o  (DOA)
  );

  x_ramb_port_out #(
    .W     (WIDTH_B),
    .WMODE (WMODE_B),
    .OREG  (OREG_B)
  ) u_out_b (
    .clk_i (CLK),
    .rst_i (RST),
    .en_i  (en_b),
    .we_i  (WEB),
    .sr_i  (SRB),
    .di_i  (DIB),
    .rd_i  (rd_b),
    .do_o  (DOB)
  );

endmodule
